// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared constants and helpers for the counter family
package counter_pkg;

  // End-of-range behaviour selectors for the SATURATE parameter
  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Width of a prescaler phase counter; a divide-by-1 still reports 1 so
  // callers never declare a zero-width vector
  function automatic int pcnt_width(input int prescale);
    return (prescale <= 1) ? 1 : $clog2(prescale);
  endfunction

endpackage

// File: rtl/count_prescaler.sv
// rtl/count_prescaler.sv - clock-enable divider producing one step tick per PRESCALE enabled cycles
module count_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic sync_clr,
  output logic step
);

  generate
    if (PRESCALE <= 1) begin : g_bypass
      // Divide-by-1 needs no state: every enabled cycle is a step
      logic unused_bypass;
      assign unused_bypass = ^{clk, rst, sync_clr};
      assign step = en;
    end else begin : g_div
      localparam int PW = pcnt_width(PRESCALE);
      localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
      localparam logic [PW-1:0] ONE  = PW'(1);

      logic [PW-1:0] pcnt;

      assign step = en && (pcnt == LAST);

      // Phase counter: advances on enabled cycles, restarts on step or clear
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          pcnt <= '0;
        end else if (sync_clr) begin
          pcnt <= '0;
        end else if (en) begin
          if (pcnt == LAST) pcnt <= '0;
          else              pcnt <= pcnt + ONE;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/updown_mod_counter.sv
// rtl/updown_mod_counter.sv - modulo up/down counter with prescaler, load/clear, wrap or saturate
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MAX_VAL  = 2**WIDTH - 1,
  parameter int PRESCALE = 1,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             evt
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic             step;
  logic             at_top;
  logic             at_bot;
  logic [WIDTH-1:0] count_nxt;
  logic             evt_nxt;

  // Any clear or load restarts the prescale period
  count_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .sync_clr (clr | load),
    .step     (step)
  );

  assign at_top = (count == MAXV);
  assign at_bot = (count == '0);
  assign tc     = (up && at_top) || (!up && at_bot);

  // Next count and boundary flag: clr beats load beats step
  always_comb begin
    count_nxt = count;
    evt_nxt   = 1'b0;
    if (clr) begin
      count_nxt = '0;
    end else if (load) begin
      count_nxt = (load_val > MAXV) ? MAXV : load_val;
    end else if (step) begin
      if (up) begin
        if (!at_top) begin
          count_nxt = count + ONE;
        end else begin
          evt_nxt   = 1'b1;
          count_nxt = (SATURATE == MODE_SAT) ? count : '0;
        end
      end else begin
        if (!at_bot) begin
          count_nxt = count - ONE;
        end else begin
          evt_nxt   = 1'b1;
          count_nxt = (SATURATE == MODE_SAT) ? count : MAXV;
        end
      end
    end
  end

  // Count and event registers; evt lines up with the count it describes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      evt   <= 1'b0;
    end else begin
      count <= count_nxt;
      evt   <= evt_nxt;
    end
  end

endmodule

// File: tb/tb_updown_mod_counter.sv
// tb/tb_updown_mod_counter.sv - self-checking bench for updown_mod_counter
module tb_updown_mod_counter;

  localparam int MAXV = 9;

  logic       clk;
  logic       rst;
  logic       en;
  logic       up;
  logic       clr;
  logic       load;
  logic [3:0] load_val;

  logic [3:0] cnt_w, cnt_s, cnt_p;
  logic       tc_w, tc_s, tc_p;
  logic       evt_w, evt_s, evt_p;

  int  nchk;
  int  nerr;
  bit  chk_en;

  // Model: instance 0 wrap/P1, 1 saturate/P1, 2 wrap/P3
  int  ps_of [3] = '{1, 1, 3};
  bit  sat_of[3] = '{1'b0, 1'b1, 1'b0};
  int  m_count[3];
  int  m_ph[3];
  bit  m_evt[3];

  updown_mod_counter #(.WIDTH(4), .MAX_VAL(MAXV), .PRESCALE(1), .SATURATE(0)) dut_w (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .count(cnt_w), .tc(tc_w), .evt(evt_w));

  updown_mod_counter #(.WIDTH(4), .MAX_VAL(MAXV), .PRESCALE(1), .SATURATE(1)) dut_s (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .count(cnt_s), .tc(tc_s), .evt(evt_s));

  updown_mod_counter #(.WIDTH(4), .MAX_VAL(MAXV), .PRESCALE(3), .SATURATE(0)) dut_p (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .count(cnt_p), .tc(tc_p), .evt(evt_p));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s[%0d] actual=%0d expected=%0d at %0t", name, idx, act, exp, $time);
    end
  endtask

  // Behavioural model: count modulo MAXV+1, step every P enabled cycles
  always @(posedge clk or negedge rst) begin : model
    int c, p;
    bit e, blk;
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        m_count[i] <= 0;
        m_ph[i]    <= 0;
        m_evt[i]   <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        c = m_count[i];
        p = m_ph[i];
        e = 1'b0;
        if (clr) begin
          c = 0;
          p = 0;
        end else if (load) begin
          c = (int'(load_val) > MAXV) ? MAXV : int'(load_val);
          p = 0;
        end else if (en) begin
          p = p + 1;
          if (p == ps_of[i]) begin
            p   = 0;
            blk = up ? (c == MAXV) : (c == 0);
            e   = blk;
            if (!(blk && sat_of[i]))
              c = up ? (c + 1) % (MAXV + 1) : (c + MAXV) % (MAXV + 1);
          end
        end
        m_count[i] <= c;
        m_ph[i]    <= p;
        m_evt[i]   <= e;
      end
    end
  end

  task automatic cmp(input int i, input logic [3:0] c, input logic t, input logic ev);
    chk("count", i, int'(c), m_count[i]);
    chk("tc", i, int'(t), (up ? (m_count[i] == MAXV) : (m_count[i] == 0)) ? 1 : 0);
    chk("evt", i, int'(ev), int'(m_evt[i]));
  endtask

  // Every-cycle compare, 2 time units after the rising edge
  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      cmp(0, cnt_w, tc_w, evt_w);
      cmp(1, cnt_s, tc_s, evt_s);
      cmp(2, cnt_p, tc_p, evt_p);
    end
  end

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  initial begin : stim
    int exp_c[4];
    int exp_e[4];
    nchk = 0; nerr = 0; chk_en = 1'b0;
    rst = 1'b0; en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0; load_val = 4'd0;
    repeat (3) tick();
    rst = 1'b1;
    chk_en = 1'b1;
    chk("rst_count", 0, int'(cnt_w), 0);
    chk("rst_evt", 0, int'(evt_w), 0);

    // Asynchronous reset mid-count
    en = 1'b1; up = 1'b1;
    repeat (5) tick();
    chk("pre_rst_count", 0, int'(cnt_w), 5);
    rst = 1'b0;
    #1;
    chk("async_rst_count", 0, int'(cnt_w), 0);
    chk("async_rst_evt", 0, int'(evt_w), 0);
    chk("async_rst_count", 2, int'(cnt_p), 0);
    tick();
    rst = 1'b1;

    // Up wrap at MAX_VAL=9
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("wrap_count", 0, int'(cnt_w), k % 10);
      chk("wrap_evt", 0, int'(evt_w), (k == 10) ? 1 : 0);
      if (k == 9) chk("wrap_tc", 0, int'(tc_w), 1);
      if (k == 10) begin
        chk("sat_top_count", 1, int'(cnt_s), 9);
        chk("sat_top_evt", 1, int'(evt_s), 1);
      end
    end

    // Down saturate from 2
    load = 1'b1; load_val = 4'd2; up = 1'b0;
    tick();
    load = 1'b0;
    chk("dsat_load", 1, int'(cnt_s), 2);
    exp_c = '{1, 0, 0, 0};
    exp_e = '{0, 0, 1, 1};
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("dsat_count", 1, int'(cnt_s), exp_c[k]);
      chk("dsat_evt", 1, int'(evt_s), exp_e[k]);
    end

    // Prescale by 3 with an enable gap mid-period
    clr = 1'b1;
    tick();
    clr = 1'b0; up = 1'b1; en = 1'b1;
    chk("ps_clr", 2, int'(cnt_p), 0);
    repeat (2) tick();
    chk("ps_hold", 2, int'(cnt_p), 0);
    tick();
    chk("ps_step1", 2, int'(cnt_p), 1);
    tick();
    en = 1'b0;
    repeat (5) tick();
    chk("ps_frozen", 2, int'(cnt_p), 1);
    en = 1'b1;
    tick();
    chk("ps_resume1", 2, int'(cnt_p), 1);
    tick();
    chk("ps_resume2", 2, int'(cnt_p), 2);

    // Priority clr > load, then clamp
    clr = 1'b1; load = 1'b1; load_val = 4'd7;
    tick();
    chk("prio_count", 0, int'(cnt_w), 0);
    chk("prio_count", 2, int'(cnt_p), 0);
    clr = 1'b0; load = 1'b1; load_val = 4'd15;
    tick();
    load = 1'b0;
    chk("clamp_count", 0, int'(cnt_w), 9);
    chk("clamp_count", 2, int'(cnt_p), 9);
    repeat (2) tick();
    chk("clamp_ps_hold", 2, int'(cnt_p), 9);
    tick();
    chk("clamp_ps_wrap", 2, int'(cnt_p), 0);
    chk("clamp_ps_evt", 2, int'(evt_p), 1);

    // Direction change on the step cycle
    load = 1'b1; load_val = 4'd9; up = 1'b1;
    tick();
    load = 1'b0;
    chk("dir_load", 0, int'(cnt_w), 9);
    chk("dir_tc_up", 0, int'(tc_w), 1);
    up = 1'b0;
    #1;
    chk("dir_tc_down", 0, int'(tc_w), 0);
    tick();
    chk("dir_count", 0, int'(cnt_w), 8);
    chk("dir_evt", 0, int'(evt_w), 0);

    // Reset discards a pending evt
    load = 1'b1; load_val = 4'd9; up = 1'b1;
    tick();
    load = 1'b0;
    tick();
    chk("pend_evt", 0, int'(evt_w), 1);
    rst = 1'b0;
    #1;
    chk("pend_evt_rst", 0, int'(evt_w), 0);
    tick();
    rst = 1'b1;

    // Mixed traffic checked against the model
    for (int k = 0; k < 300; k++) begin
      en       = ($urandom_range(0, 3) != 0);
      up       = ($urandom_range(0, 1) == 1);
      clr      = ($urandom_range(0, 19) == 0);
      load     = ($urandom_range(0, 9) == 0);
      load_val = 4'($urandom_range(0, 15));
      tick();
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
